// File: rtl/pet_cycle_gen.sv
// rtl/pet_cycle_gen.sv - PET master cycle sequencer (optional cycle counter: PET_CYCLE_COUNT_EN)
//
// Divides the 32 MHz core clock into 32 subclocks per CPU cycle. The subclock
// index runs freely so video timing is never disturbed; only the CPU clock
// enable is gated for stop, single-step and turbo. Every mode change is taken
// at the cnt31==31 boundary so no CPU cycle is ever truncated.

module pet_cycle_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_speed,
  input  logic        clk_stop,
  input  logic        step,
`ifdef PET_CYCLE_COUNT_EN
  input  logic        cycles_clr,
  output logic [31:0] cycles_o,
`endif
  output logic [4:0]  cnt31_o,
  output logic        ce_1m_o,
  output logic        cycle_end_o,
  output logic        stopped_o,
  output logic        turbo_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STOPPED    = 2'd1,
    ST_STEP_ARMED = 2'd2
  } state_t;

  // Subclock positions with all bits under this mask clear are turbo CE slots.
  localparam logic [4:0] TURBO_MASK = 5'(5'h1F >> TURBO_SHIFT);

  state_t                 state_q, state_d;
  logic [4:0]             cnt31_q, cnt31_d;
  logic                   ce_1m_q, ce_1m_d;
  logic                   cycle_end_q, cycle_end_d;
  logic                   stopped_q, stopped_d;
  logic                   turbo_q, turbo_d;
  logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
  logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
  logic                   step_prev_q, step_prev_d;

  logic stop_s;
  logic step_s;
  logic step_pulse;
  logic boundary;
  logic slot;

  assign stop_s     = stop_sync_q[SYNC_STAGES-1];
  assign step_s     = step_sync_q[SYNC_STAGES-1];
  assign step_pulse = step_s & ~step_prev_q;
  assign boundary   = (cnt31_q == 5'd31);

  // Synchronizer shift chains and step edge-detector history.
  always_comb begin
    stop_sync_d = (stop_sync_q << 1) | SYNC_STAGES'(clk_stop);
    step_sync_d = (step_sync_q << 1) | SYNC_STAGES'(step);
    step_prev_d = step_s;
  end

  // Free-running subclock count and the boundary-deferred turbo select.
  always_comb begin
    cnt31_d     = cnt31_q + 5'd1;
    cycle_end_d = (cnt31_d == 5'd31);
    turbo_d     = boundary ? clk_speed : turbo_q;
  end

  // Sequencer next state; stop/release decisions only at the cycle boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (boundary && stop_s) begin
          state_d = ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        // Releasing the stop at the boundary beats a coincident step.
        if (boundary && !stop_s) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d = ST_STEP_ARMED;
        end
      end
      ST_STEP_ARMED: begin
        // Extra step edges here are dropped; the armed cycle fires once.
        if (boundary) begin
          state_d = stop_s ? ST_STOPPED : ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // CE generation, looking at the subclock index the next clk will present.
  always_comb begin
    ce_1m_d = 1'b0;
    if (turbo_q) begin
      slot = ((cnt31_d & TURBO_MASK) == 5'd0);
    end else begin
      slot = (cnt31_d == 5'd0);
    end
    if (state_d == ST_RUN) begin
      ce_1m_d = slot;
    end
    // A released single step is one pulse at subclock 0, even in turbo.
    if (state_q == ST_STEP_ARMED && boundary) begin
      ce_1m_d = 1'b1;
    end
    stopped_d = (state_d != ST_RUN);
  end

  // Sequencer register set; reset returns to RUN and drops any armed step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      cnt31_q     <= 5'd0;
      ce_1m_q     <= 1'b0;
      cycle_end_q <= 1'b0;
      stopped_q   <= 1'b0;
      turbo_q     <= 1'b0;
      stop_sync_q <= '0;
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt31_q     <= cnt31_d;
      ce_1m_q     <= ce_1m_d;
      cycle_end_q <= cycle_end_d;
      stopped_q   <= stopped_d;
      turbo_q     <= turbo_d;
      stop_sync_q <= stop_sync_d;
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign cnt31_o     = cnt31_q;
  assign ce_1m_o     = ce_1m_q;
  assign cycle_end_o = cycle_end_q;
  assign stopped_o   = stopped_q;
  assign turbo_o     = turbo_q;

`ifdef PET_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Count issued CPU cycles; a clear overrides a coincident increment.
  always_comb begin
    cycles_d = cycles_q;
    if (cycles_clr) begin
      cycles_d = 32'd0;
    end else if (ce_1m_q) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`endif

endmodule
